// File: rtl/dm_cache_pkg.sv
// Shared widths, FSM state type and address field helpers for the
// direct-mapped write-through cache controller.
package dm_cache_pkg;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 32;
  localparam int INDEX_W  = 10;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int HIT_W    = 14;
  localparam int WORDS    = 1 << OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;

  localparam logic [HIT_W-1:0] HIT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_FETCH,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/dm_cache_controller_if.sv
// CPU request port and main-memory port of the cache controller.
// slave = controller view, master = traffic source / memory model view.
interface dm_cache_controller_if;
  import dm_cache_pkg::*;

  logic              cache_read;
  logic              cache_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              cache_ready;
  logic [DATA_W-1:0] rdata;
  logic [HIT_W-1:0]  hit_count;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              mem_ready;

  modport slave (
    input  cache_read, cache_write, address, wdata, mem_rdata, mem_rvalid, mem_ready,
    output cache_ready, rdata, hit_count, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output cache_read, cache_write, address, wdata, mem_rdata, mem_rvalid, mem_ready,
    input  cache_ready, rdata, hit_count, mem_read, mem_write, mem_address, mem_wdata
  );

endinterface

// File: rtl/dm_cache_array.sv
// Tag, valid and data storage. Reads are combinational by index; only the
// valid bits are reset so a partially filled line can never appear valid.
module dm_cache_array
  import dm_cache_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INDEX_W-1:0]            index_i,
  output logic                          valid_o,
  output logic [TAG_W-1:0]              tag_o,
  output logic [WORDS-1:0][DATA_W-1:0]  words_o,
  input  logic                          word_we_i,
  input  logic [OFFSET_W-1:0]           word_sel_i,
  input  logic [DATA_W-1:0]             word_data_i,
  input  logic                          line_we_i,
  input  logic [TAG_W-1:0]              line_tag_i
);

  logic [LINES-1:0]                 valid_q;
  logic [TAG_W-1:0]                 tag_q  [LINES];
  logic [WORDS-1:0][DATA_W-1:0]     data_q [LINES];

  // Valid bits: cleared by reset, set when a line fill completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (line_we_i) begin
      valid_q[index_i] <= 1'b1;
    end
  end

  // Data words and tags: unreset storage written by fills and write hits.
  always_ff @(posedge clk) begin
    if (word_we_i) begin
      data_q[index_i][word_sel_i] <= word_data_i;
    end
    if (line_we_i) begin
      tag_q[index_i] <= line_tag_i;
    end
  end

  assign valid_o = valid_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign words_o = data_q[index_i];

endmodule

// File: rtl/dm_cache_controller.sv
// Direct-mapped write-through cache controller: FSM, fill beat counter,
// saturating read-hit counter and registered memory-side outputs.
//
// state   | meaning
// IDLE    | wait for a CPU request, latch address/data
// COMPARE | tag lookup; answer a read hit, launch a fetch or a write-through
// FETCH   | collect 4 memory beats into the line
// WRITE   | hold mem_write until memory accepts it
// DONE    | guard cycle so a held request is not re-accepted
module dm_cache_controller
  import dm_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  dm_cache_controller_if.slave  bus
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [HIT_W-1:0]    hit_q, hit_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                         line_valid;
  logic [TAG_W-1:0]             line_tag;
  logic [WORDS-1:0][DATA_W-1:0] line_words;
  logic                         word_we;
  logic [OFFSET_W-1:0]          word_sel;
  logic [DATA_W-1:0]            word_data;
  logic                         line_we;
  logic                         hit;

  dm_cache_array u_array (
    .clk         (clk),
    .rst         (rst),
    .index_i     (get_index(addr_q)),
    .valid_o     (line_valid),
    .tag_o       (line_tag),
    .words_o     (line_words),
    .word_we_i   (word_we),
    .word_sel_i  (word_sel),
    .word_data_i (word_data),
    .line_we_i   (line_we),
    .line_tag_i  (get_tag(addr_q))
  );

  assign hit = line_valid && (line_tag == get_tag(addr_q));

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      beat_q      <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      hit_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      beat_q      <= beat_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      hit_q       <= hit_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state, next-output and array write control.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    beat_d      = beat_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    hit_d       = hit_q;
    mem_read_d  = 1'b0;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    word_we     = 1'b0;
    word_sel    = get_offset(addr_q);
    word_data   = wdata_q;
    line_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cache_write) begin
          addr_d  = bus.address;
          wdata_d = bus.wdata;
          is_wr_d = 1'b1;
          state_d = S_COMPARE;
        end else if (bus.cache_read) begin
          addr_d  = bus.address;
          is_wr_d = 1'b0;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (is_wr_q) begin
          // No write-allocate: only an existing line is updated.
          word_we     = hit;
          mem_write_d = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          state_d     = S_WRITE;
        end else if (hit) begin
          rdata_d = line_words[get_offset(addr_q)];
          ready_d = 1'b1;
          hit_d   = (hit_q == HIT_MAX) ? hit_q : hit_q + 1'b1;
          state_d = S_DONE;
        end else begin
          mem_read_d = 1'b1;
          mem_addr_d = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          beat_d     = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.mem_rvalid) begin
          word_we   = 1'b1;
          word_sel  = beat_q;
          word_data = bus.mem_rdata;
          beat_d    = beat_q + 1'b1;
          if (beat_q == OFFSET_W'(WORDS - 1)) begin
            // Last beat is not in the array yet, so forward it directly.
            line_we = 1'b1;
            rdata_d = (get_offset(addr_q) == OFFSET_W'(WORDS - 1)) ?
                      bus.mem_rdata : line_words[get_offset(addr_q)];
            ready_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        if (bus.mem_ready) begin
          mem_write_d = 1'b0;
          ready_d     = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.cache_ready = ready_q;
  assign bus.rdata       = rdata_q;
  assign bus.hit_count   = hit_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: doc/dm_cache_controller.md
# dm_cache_controller

Direct-mapped, write-through cache controller that serves the CPU-side request port (`cache_read`/`cache_write`/`address`/`cache_ready`/`hit_count`). It sits between the CPU traffic source and main memory. Lookups return data with fixed latency on a hit. Misses fetch a 4-word block from memory as a burst and answer the CPU once the line is filled.

## Interface
Parameters:
- ADDR_W, 15, word address width (32K words)
- DATA_W, 32, data word width
- INDEX_W, 10, line index width (1024 lines)
- OFFSET_W, 2, word-in-block width (4 words per block)
- HIT_W, 14, hit counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cache_read  in  1  read request, level; may be held high continuously
- cache_write  in  1  write request, level; wins over cache_read if both are high
- address  in  ADDR_W  word address of the request
- wdata  in  DATA_W  write data
- cache_ready  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid while cache_ready=1
- hit_count  out  HIT_W  number of read hits
- mem_read  out  1  one-cycle block-fetch request
- mem_write  out  1  write-through request, held until accepted
- mem_address  out  ADDR_W  block-aligned address for fetches; word address for writes
- mem_wdata  out  DATA_W  write-through data
- mem_rdata  in  DATA_W  fetch beat data
- mem_rvalid  in  1  fetch beat strobe; exactly 4 beats per fetch, word 0 to word 3, gaps allowed
- mem_ready  in  1  write-through accepted

## Operation
- Address split:
  - offset = address[1:0]
  - index = address[11:2]
  - tag = address[14:12]
- Storage per line: valid bit, 3-bit tag, 4 data words. Only the valid bits are reset.
- FSM states: IDLE, COMPARE, FETCH, WRITE, DONE.
- IDLE
  - If cache_write: latch address and wdata, go to COMPARE.
  - Else if cache_read: latch address, go to COMPARE.
  - Otherwise stay in IDLE.
- COMPARE, hit = valid[index] && tag match:
  - Read hit: rdata ← word[offset]; cache_ready ← 1; hit_count +1, saturating at 2^HIT_W−1; go to DONE.
  - Read miss: mem_read ← 1 for one cycle; mem_address ← {tag, index, 2'b00}; beat counter ← 0; go to FETCH.
  - Write, hit or miss: on a hit, update word[offset]. Then mem_write ← 1, mem_address ← address, mem_wdata ← wdata; go to WRITE. There is no write-allocate.
- FETCH
  - Each mem_rvalid stores mem_rdata into word[beat] and increments beat.
  - On beat 3: set tag and valid; rdata ← requested word (taken from mem_rdata if offset=3); cache_ready ← 1; go to DONE.
  - A miss never increments hit_count.
- WRITE: hold mem_write until mem_ready is sampled high. Then mem_write ← 0, cache_ready ← 1, go to DONE. Writes never count as hits.
- DONE: cache_ready ← 0, go to IDLE. This guard cycle stops a held request from being re-accepted before the CPU has advanced its address.
- mem_rvalid and mem_ready outside FETCH or WRITE are ignored.

## Timing
- Reset values:
  - Outputs: cache_ready, rdata, hit_count, mem_read, mem_write, mem_address, mem_wdata all 0.
  - State: FSM in IDLE; all valid bits cleared.
- Read hit latency:
  - Request sampled at edge E0; cache_ready high during the cycle after E1.
  - Next request sampled at E3, so throughput is one access per 3 cycles.
- Read miss latency: mem_read pulses in the cycle after E1; cache_ready rises the cycle after the 4th mem_rvalid.
- Write: cache_ready rises the cycle after mem_ready is sampled.
- Reset during FETCH or WRITE:
  - FSM returns to IDLE and the partial line is discarded (valid stays 0).
  - Beats still in flight are ignored.
- hit_count saturates at 16383; it never wraps.

## Structure
- Package dm_cache_pkg holds:
  - width constants ADDR_W, DATA_W, INDEX_W, OFFSET_W, TAG_W = ADDR_W−INDEX_W−OFFSET_W;
  - the state enum;
  - tag, index and offset field extraction functions.
- Sub-module dm_cache_array holds the tag, valid and data arrays:
  - combinational read by index;
  - synchronous word and tag writes;
  - asynchronous clear of the valid bits.
- The top level contains the FSM, beat counter, hit counter and memory-side registers.

## Test plan
- After reset, read 1024; memory returns 0xA0..0xA3 → mem_read pulse with mem_address=1024, cache_ready, rdata=0xA0, hit_count=0.
- Then read 1025 → no mem_read; cache_ready 2 cycles after sampling; rdata=0xA1; hit_count=1.
- Read 5120 (same index as 1024, tag 1), then 1024 → both miss and refill; hit_count unchanged.
- Write 0x55 to 1026 with mem_ready after 3 cycles → mem_write held 3 cycles with mem_address=1026; then cache_ready. A later read of 1026 hits with rdata=0x55.
- Stream of sequential reads 1024..9215 (8192 accesses), memory at fixed 2-cycle beat gaps → 2048 fetches, hit_count=6144.
- Assert rst after the 2nd fetch beat → all outputs 0 next cycle. Re-reading 1024 misses again; stale beats are ignored.
